// File: rtl/udp_reg_ring_master_pkg.sv
// -----------------------------------------------------------------------------
// udp_reg_ring_master_pkg
//   Shared widths and constants for the UDP register ring master, plus the
//   helper that picks the data word handed back to the host on completion.
// -----------------------------------------------------------------------------
package udp_reg_ring_master_pkg;

   localparam int UDP_REG_ADDR_WIDTH  = 23;
   localparam int CPCI_NF2_DATA_WIDTH = 32;

   // Data word returned to the host when an access was unclaimed or timed out.
   localparam logic [CPCI_NF2_DATA_WIDTH-1:0] UDP_REG_ERR_DATA = 32'hDEAD_BEEF;

   // Host-visible data for a completed access.
   // Claimed reads return ring data, claimed writes return zero, and
   // anything unclaimed returns the error marker.
   function automatic logic [CPCI_NF2_DATA_WIDTH-1:0] ret_data(
      input logic                           is_read,
      input logic                           claimed,
      input logic [CPCI_NF2_DATA_WIDTH-1:0] ring_data
   );
      logic [CPCI_NF2_DATA_WIDTH-1:0] res;
      if (!claimed) begin
         res = UDP_REG_ERR_DATA;
      end else if (is_read) begin
         res = ring_data;
      end else begin
         res = {CPCI_NF2_DATA_WIDTH{1'b0}};
      end
      return res;
   endfunction

endpackage

// File: rtl/udp_reg_ring_master.sv
// -----------------------------------------------------------------------------
// udp_reg_ring_master
//   Head/tail initiator of the UDP register ring. Takes one host access at a
//   time, injects it at the ring head, waits for it to come back at the tail
//   and reports read data / write completion to the host. Accesses nobody
//   claimed, or that never return, complete with err=1 and 32'hDEAD_BEEF.
//
// Ports
//   clk, reset                 ring clock, synchronous active-low reset
//   core_reg_*                 host side: req/rd_wr_L/addr/wr_data in,
//                              busy/ack/rd_data/err out
//   reg_*_out                  ring head (request injected here)
//   reg_*_in                   ring tail (request returns here)
// -----------------------------------------------------------------------------
module udp_reg_ring_master
   import udp_reg_ring_master_pkg::*;
#(
   parameter int UDP_REG_SRC_WIDTH = 2,
   parameter int SRC_ID            = 0,
   parameter int TIMEOUT_BITS      = 8
) (
   input  logic                           clk,
   input  logic                           reset,

   input  logic                           core_reg_req,
   input  logic                           core_reg_rd_wr_L,
   input  logic [UDP_REG_ADDR_WIDTH-1:0]  core_reg_addr,
   input  logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_wr_data,
   output logic                           core_reg_busy,
   output logic                           core_reg_ack,
   output logic [CPCI_NF2_DATA_WIDTH-1:0] core_reg_rd_data,
   output logic                           core_reg_err,

   output logic                           reg_req_out,
   output logic                           reg_ack_out,
   output logic                           reg_rd_wr_L_out,
   output logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_out,
   output logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_out,
   output logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_out,

   input  logic                           reg_req_in,
   input  logic                           reg_ack_in,
   input  logic                           reg_rd_wr_L_in,
   input  logic [UDP_REG_ADDR_WIDTH-1:0]  reg_addr_in,
   input  logic [CPCI_NF2_DATA_WIDTH-1:0] reg_data_in,
   input  logic [UDP_REG_SRC_WIDTH-1:0]   reg_src_in
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      ISSUE = ST_ISSUE,
      WAIT  = ST_WAIT,
      DONE  = ST_DONE
   } state_e;

   localparam logic [UDP_REG_SRC_WIDTH-1:0] SRC_TAG  = UDP_REG_SRC_WIDTH'(SRC_ID);
   localparam logic [TIMEOUT_BITS-1:0]      CNT_MAX  = {TIMEOUT_BITS{1'b1}};
   // The cycle whose increment reaches all-ones is the one that times out.
   localparam logic [TIMEOUT_BITS-1:0]      CNT_LAST = CNT_MAX - {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};

   state_e                           state_q, state_d;
   logic [TIMEOUT_BITS-1:0]          cnt_q;
   logic                             busy_q, busy_d;
   logic                             ack_q, ack_d;
   logic [CPCI_NF2_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
   logic                             err_q, err_d;
   logic                             req_out_q, req_out_d;
   logic                             rd_wr_L_out_q, rd_wr_L_out_d;
   logic [UDP_REG_ADDR_WIDTH-1:0]    addr_out_q, addr_out_d;
   logic [CPCI_NF2_DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic [UDP_REG_SRC_WIDTH-1:0]     src_out_q, src_out_d;
   logic                             match_s;
   logic                             timeout_s;

   // The head fields double as the latched request: they hold after ISSUE,
   // so the return is compared against them directly.
   assign match_s   = reg_req_in
                      && (reg_src_in == SRC_TAG)
                      && (reg_addr_in == addr_out_q)
                      && (reg_rd_wr_L_in == rd_wr_L_out_q);
   assign timeout_s = (cnt_q == CNT_LAST);

   // Next-state and next-output logic for the access FSM.
   always_comb begin
      state_d       = state_q;
      busy_d        = busy_q;
      ack_d         = 1'b0;
      rd_data_d     = rd_data_q;
      err_d         = err_q;
      req_out_d     = 1'b0;
      rd_wr_L_out_d = rd_wr_L_out_q;
      addr_out_d    = addr_out_q;
      data_out_d    = data_out_q;
      src_out_d     = src_out_q;
      case (state_q)
         IDLE: begin
            if (core_reg_req) begin
               state_d       = ISSUE;
               busy_d        = 1'b1;
               req_out_d     = 1'b1;
               rd_wr_L_out_d = core_reg_rd_wr_L;
               addr_out_d    = core_reg_addr;
               data_out_d    = core_reg_rd_wr_L ? {CPCI_NF2_DATA_WIDTH{1'b0}} : core_reg_wr_data;
               src_out_d     = SRC_TAG;
            end else begin
               state_d = IDLE;
            end
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            // A match beats a simultaneous timeout.
            if (match_s) begin
               state_d   = DONE;
               busy_d    = 1'b0;
               ack_d     = 1'b1;
               err_d     = ~reg_ack_in;
               rd_data_d = ret_data(rd_wr_L_out_q, reg_ack_in, reg_data_in);
            end else if (timeout_s) begin
               state_d   = DONE;
               busy_d    = 1'b0;
               ack_d     = 1'b1;
               err_d     = 1'b1;
               rd_data_d = UDP_REG_ERR_DATA;
            end else begin
               state_d = WAIT;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         busy_q        <= 1'b0;
         ack_q         <= 1'b0;
         rd_data_q     <= {CPCI_NF2_DATA_WIDTH{1'b0}};
         err_q         <= 1'b0;
         req_out_q     <= 1'b0;
         rd_wr_L_out_q <= 1'b0;
         addr_out_q    <= {UDP_REG_ADDR_WIDTH{1'b0}};
         data_out_q    <= {CPCI_NF2_DATA_WIDTH{1'b0}};
         src_out_q     <= {UDP_REG_SRC_WIDTH{1'b0}};
      end else begin
         state_q       <= state_d;
         busy_q        <= busy_d;
         ack_q         <= ack_d;
         rd_data_q     <= rd_data_d;
         err_q         <= err_d;
         req_out_q     <= req_out_d;
         rd_wr_L_out_q <= rd_wr_L_out_d;
         addr_out_q    <= addr_out_d;
         data_out_q    <= data_out_d;
         src_out_q     <= src_out_d;
      end
   end

   // Timeout counter: cleared on issue, saturating count while waiting.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= {TIMEOUT_BITS{1'b0}};
      end else if (state_q == ISSUE) begin
         cnt_q <= {TIMEOUT_BITS{1'b0}};
      end else if ((state_q == WAIT) && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
      end else begin
         cnt_q <= cnt_q;
      end
   end

   assign core_reg_busy    = busy_q;
   assign core_reg_ack     = ack_q;
   assign core_reg_rd_data = rd_data_q;
   assign core_reg_err     = err_q;
   assign reg_req_out      = req_out_q;
   assign reg_ack_out      = 1'b0;
   assign reg_rd_wr_L_out  = rd_wr_L_out_q;
   assign reg_addr_out     = addr_out_q;
   assign reg_data_out     = data_out_q;
   assign reg_src_out      = src_out_q;

endmodule
